// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Walks a 64-bit PC, issues one
//             outstanding request at a time to IMEM, buffers returned words
//             in a small FIFO and hands them to dispatch as single-cycle
//             out_fetch_done pulses. Accepts branch redirects and stops
//             fetching after an HLT word.
//  Ports    : in_clk / in_rst_n (sync, active-low)  clock and reset
//             in_stall                             dispatch back-pressure
//             in_redirect_valid / in_redirect_pc   branch redirect
//             out_imem_req / out_imem_addr         IMEM request pulse + addr
//             in_imem_valid / in_imem_data         IMEM response
//             out_fetch_insnbits / out_fetch_pc    word + PC to dispatch
//             out_fetch_done                       delivery strobe
//             out_halted                           HLT fetched, idle
//             out_fifo_count                       buffered entries
//  Options  : FETCH_NOP_DROP_EN - when defined, NOP words (32'hD503201F)
//             are discarded instead of being delivered.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef INSNBITS_SIZE
`define INSNBITS_SIZE 32
`endif

module fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic                          in_stall,
    input  logic                          in_redirect_valid,
    input  logic [63:0]                   in_redirect_pc,
    output logic                          out_imem_req,
    output logic [63:0]                   out_imem_addr,
    input  logic                          in_imem_valid,
    input  logic [`INSNBITS_SIZE-1:0]     in_imem_data,
    output logic [`INSNBITS_SIZE-1:0]     out_fetch_insnbits,
    output logic [63:0]                   out_fetch_pc,
    output logic                          out_fetch_done,
    output logic                          out_halted,
    output logic [$clog2(FIFO_DEPTH):0]   out_fifo_count
);

    localparam int c_insn_w  = `INSNBITS_SIZE;
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_entry_w = 64 + c_insn_w;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t                 state_q,  state_d;
    logic [63:0]            pc_q,     pc_d;
    logic [c_ptr_w-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]     count_q,  count_d;
    logic                   req_q,    req_d;
    logic [63:0]            addr_q,   addr_d;
    logic                   done_q,   done_d;
    logic [c_insn_w-1:0]    insn_q,   insn_d;
    logic [63:0]            fpc_q,    fpc_d;
    logic                   halted_q, halted_d;
    logic [c_entry_w-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [c_entry_w-1:0]   fifo_mem_d [FIFO_DEPTH];

    logic w_is_hlt;
    logic w_is_nop;
    logic w_take;   // response accepted and destined for dispatch
    logic w_push;
    logic w_pop;

    assign w_is_hlt = (in_imem_data[31:21] == 11'b11010100010) &&
                      (in_imem_data[4:0] == 5'b00000);

`ifdef FETCH_NOP_DROP_EN
    assign w_is_nop = (in_imem_data[31:0] == 32'hD503201F);
`else
    assign w_is_nop = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        done_d     = 1'b0;
        insn_d     = insn_q;
        fpc_d      = fpc_q;
        fifo_mem_d = fifo_mem_q;
        w_take     = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;

        if (in_redirect_valid) begin
            pc_d     = in_redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            // A request still in flight (issued this cycle, or awaited and
            // not answered now) must be drained before the next one goes out.
            if (((state_q == ST_WAIT || state_q == ST_DRAIN) && !in_imem_valid) ||
                (state_q == ST_FETCH && req_q)) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // req_q high means the request is on the bus this cycle
                    if (req_q) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (in_imem_valid) begin
                        pc_d    = pc_q + 64'd4;
                        w_take  = !w_is_nop;
                        state_d = w_is_hlt ? ST_HALT : ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (in_imem_valid) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase

            // Dispatch side: the head wins; an empty FIFO is bypassed.
            if (!in_stall && count_q != '0) begin
                w_pop  = 1'b1;
                done_d = 1'b1;
                fpc_d  = fifo_mem_q[rd_ptr_q][c_entry_w-1:c_insn_w];
                insn_d = fifo_mem_q[rd_ptr_q][c_insn_w-1:0];
            end else if (!in_stall && w_take) begin
                done_d = 1'b1;
                fpc_d  = pc_q;
                insn_d = in_imem_data;
            end
            w_push = w_take && (in_stall || count_q != '0);

            if (w_push) begin
                fifo_mem_d[wr_ptr_q] = {pc_q, in_imem_data};
                wr_ptr_d             = wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end
            count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    // The request strobe is registered from next-state values so a request
    // goes out in the first cycle the FSM sits in FETCH with room to spare.
    assign req_d    = (state_d == ST_FETCH) && (count_d < c_depth);
    assign addr_d   = pc_d;
    assign halted_d = (state_d == ST_HALT);

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            insn_q   <= '0;
            fpc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            insn_q   <= insn_d;
            fpc_q    <= fpc_d;
            halted_q <= halted_d;
        end
    end

    // Buffer storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge in_clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign out_imem_req       = req_q;
    assign out_imem_addr      = addr_q;
    assign out_fetch_done     = done_q;
    assign out_fetch_insnbits = insn_q;
    assign out_fetch_pc       = fpc_q;
    assign out_halted         = halted_q;
    assign out_fifo_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. An IMEM model with
//             configurable latency answers requests; a queue-based reference
//             model predicts every output each cycle. Directed scenarios are
//             followed by a randomized run.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef INSNBITS_SIZE
`define INSNBITS_SIZE 32
`endif

module tb_fetch_unit;

    localparam int          W     = `INSNBITS_SIZE;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h1000;
    localparam logic [31:0] HLT   = 32'hD4400000;
    localparam logic [31:0] NOP   = 32'hD503201F;
    localparam logic [31:0] ADDW  = 32'h8B020020;
    localparam logic [31:0] SUBW  = 32'hCB020020;
`ifdef FETCH_NOP_DROP_EN
    localparam int NOP_PULSES = 2;
`else
    localparam int NOP_PULSES = 3;
`endif

    logic          clk, rst_n, stall, rvalid, ivalid;
    logic [63:0]   rpc;
    logic [W-1:0]  idata;
    logic          o_req, o_done, o_halted;
    logic [63:0]   o_addr, o_fpc;
    logic [W-1:0]  o_insn;
    logic [2:0]    o_count;

    fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .in_clk             (clk),
        .in_rst_n           (rst_n),
        .in_stall           (stall),
        .in_redirect_valid  (rvalid),
        .in_redirect_pc     (rpc),
        .out_imem_req       (o_req),
        .out_imem_addr      (o_addr),
        .in_imem_valid      (ivalid),
        .in_imem_data       (idata),
        .out_fetch_insnbits (o_insn),
        .out_fetch_pc       (o_fpc),
        .out_fetch_done     (o_done),
        .out_halted         (o_halted),
        .out_fifo_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; logic [63:0] addr; int ep; } pend_t;
    typedef struct { logic [63:0] pc; logic [W-1:0] insn; } ent_t;

    pend_t        pend[$];
    ent_t         mq[$];
    logic [W-1:0] ovr [logic [63:0]];
    logic [63:0]  req_log[$];
    int           req_cyc[$];
    logic [63:0]  done_log[$];
    logic [W-1:0] done_insn[$];
    int           done_cyc[$];

    int           n_chk = 0, n_pass = 0, cyc = 0, lat_fixed = 1;
    logic [63:0]  m_pc, m_fpc;
    logic [W-1:0] m_insn;
    bit           m_done, m_halted, m_out, m_just_reset;
    int           m_ep;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] word(input logic [63:0] a);
        if (ovr.exists(a)) return ovr[a];
        case (a[9:2])
            8'h5A:   return W'(HLT);
            8'h33:   return W'(NOP);
            default: return W'(32'h8B000000 | {16'h0, a[17:2]});
        endcase
    endfunction

    function automatic bit is_hlt(input logic [W-1:0] w);
        return (w[31:0] & 32'hFFE0001F) == HLT;
    endfunction

    function automatic bit is_drop(input logic [W-1:0] w);
`ifdef FETCH_NOP_DROP_EN
        return w[31:0] == NOP;
`else
        return w[31:0] == 32'h0 && w[31:0] != 32'h0;
`endif
    endfunction

    function automatic int find_pc(input logic [63:0] pc, input int from);
        for (int i = from; i < done_log.size(); i++) if (done_log[i] == pc) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        mq.delete(); pend.delete();
        m_pc = RPC; m_done = 0; m_halted = 0; m_out = 0; m_just_reset = 1;
        m_fpc = '0; m_insn = '0;
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model,
    // then advance the model across the coming edge.
    task automatic step(input bit st, input bit rd, input logic [63:0] rp, input bit rn);
        bit    exp_req, resp, ok;
        pend_t p, np;
        ent_t  e;
        logic [W-1:0] w;
        stall = st; rvalid = rd; rpc = rp; rst_n = rn;
        resp = 0; ivalid = 1'b0; idata = '0; w = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front(); resp = 1; w = word(p.addr);
            ivalid = 1'b1; idata = w;
        end
        exp_req = !m_just_reset && !m_out && !m_halted && mq.size() < DEPTH;
        chk("imem_req", o_req, exp_req);
        if (exp_req && o_req) chk("imem_addr", o_addr, m_pc);
        chk("fetch_done", o_done, m_done);
        if (m_done && o_done) begin
            chk("fetch_pc", o_fpc, m_fpc);
            chk("fetch_insn", o_insn, m_insn);
        end
        chk("halted", o_halted, m_halted);
        chk("fifo_count", o_count, mq.size());
        if (o_req) begin req_log.push_back(o_addr); req_cyc.push_back(cyc); end
        if (o_done) begin done_log.push_back(o_fpc); done_insn.push_back(o_insn); done_cyc.push_back(cyc); end
        if (rn && o_req) begin
            np.due = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3)));
            np.addr = o_addr; np.ep = m_ep;
            pend.push_back(np);
        end
        if (!rn) begin
            model_reset();
        end else begin
            m_just_reset = 0;
            if (resp) m_out = 0;
            if (exp_req) m_out = 1;
            ok = resp && p.ep == m_ep && !rd;
            if (rd) begin
                m_pc = rp; mq.delete(); m_halted = 0; m_done = 0; m_ep++;
            end else begin
                if (ok) begin
                    m_pc = m_pc + 64'd4;
                    if (!is_drop(w)) begin e.pc = p.addr; e.insn = w; mq.push_back(e); end
                    if (is_hlt(w)) m_halted = 1;
                end
                if (!st && mq.size() > 0) begin
                    e = mq.pop_front(); m_done = 1; m_fpc = e.pc; m_insn = e.insn;
                end else begin
                    m_done = 0;
                end
            end
        end
        @(posedge clk); #1; cyc++;
    endtask

    task automatic run(input int n, input bit st);
        for (int i = 0; i < n; i++) step(st, 0, 64'h0, 1);
    endtask

    task automatic wait_req(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (o_req) return;
            step(0, 0, 64'h0, 1);
        end
        chk("wait_req_timeout", 64'd0, 64'd1);
    endtask

    task automatic clear_logs();
        req_log.delete(); req_cyc.delete(); done_log.delete(); done_insn.delete(); done_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] stale, dropped;
        int n0, mark, idx, cnt;
        bit found;
        rst_n = 1'b0; stall = 1'b0; rvalid = 1'b0; rpc = '0; ivalid = 1'b0; idata = '0;
        m_ep = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_req", o_req, 0);
        chk("reset_count", o_count, 0);

        // 1: sequential fetch at latency 1
        lat_fixed = 1; clear_logs();
        run(12, 0);
        chk("t1_nreq", req_log.size() >= 3, 1);
        if (req_log.size() >= 3) begin
            chk("t1_addr0", req_log[0], 64'h1000);
            chk("t1_addr1", req_log[1], 64'h1004);
            chk("t1_addr2", req_log[2], 64'h1008);
            chk("t1_period", req_cyc[1] - req_cyc[0], 2);
        end
        chk("t1_ndone", done_log.size() >= 2, 1);
        if (done_log.size() >= 2) begin
            chk("t1_done_pc0", done_log[0], 64'h1000);
            chk("t1_done_pc1", done_log[1], 64'h1004);
            chk("t1_done_insn0", done_insn[0], 64'h8B000400);
            chk("t1_latency", done_cyc[0] - req_cyc[0], 2);
        end

        // 2: long stall fills the buffer, release drains back-to-back
        step(1, 0, 64'h0, 1);
        n0 = done_log.size();
        run(19, 1);
        chk("t2_no_done", done_log.size(), n0);
        chk("t2_count_full", o_count, 4);
        chk("t2_no_req", o_req, 0);
        done_cyc.delete();
        run(6, 0);
        chk("t2_pulses", done_cyc.size() >= 4, 1);
        if (done_cyc.size() >= 4) chk("t2_back_to_back", done_cyc[3] - done_cyc[0], 3);

        // 3: redirect while waiting, then redirect coincident with a response
        lat_fixed = 3;
        wait_req(20);
        step(0, 0, 64'h0, 1);
        stale = req_log[$];
        mark = done_log.size();
        step(0, 1, 64'h2000, 1);
        wait_req(20);
        chk("t3_redir_addr", o_addr, 64'h2000);
        step(0, 0, 64'h0, 1);
        for (int i = 0; i < 10 && !(pend.size() > 0 && pend[0].due == cyc); i++) step(0, 0, 64'h0, 1);
        dropped = (pend.size() > 0) ? pend[0].addr : 64'h0;
        chk("t3_dropped_addr", dropped, 64'h2000);
        step(0, 1, 64'h2400, 1);
        n0 = done_log.size();
        run(14, 0);
        chk("t3_stale_absent", find_pc(stale, mark) >= 0, 0);
        chk("t3_coinc_absent", find_pc(64'h2000, mark) >= 0, 0);
        chk("t3_next_pc", (done_log.size() > n0) ? done_log[n0] : 64'hX, 64'h2400);

        // 4: HLT at 0x1008 stops fetch; redirect resumes
        step(0, 0, 64'h0, 0);
        lat_fixed = 1; ovr[64'h1008] = W'(HLT); clear_logs();
        run(20, 0);
        idx = find_pc(64'h1008, 0);
        chk("t4_hlt_delivered", idx >= 0, 1);
        if (idx >= 0) chk("t4_hlt_word", done_insn[idx], 64'(HLT));
        chk("t4_halted", o_halted, 1);
        chk("t4_nreq", req_log.size(), 3);
        step(0, 1, 64'h3000, 1);
        chk("t4_unhalted", o_halted, 0);
        wait_req(10);
        chk("t4_resume_addr", o_addr, 64'h3000);

        // 5: reset while waiting with two buffered entries
        step(0, 0, 64'h0, 0);
        ovr.delete(); lat_fixed = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (o_count == 2 && m_out) found = 1;
            else step(1, 0, 64'h0, 1);
        end
        chk("t5_setup", found, 1);
        step(1, 0, 64'h0, 0);
        chk("t5_req0", o_req, 0);
        chk("t5_addr0", o_addr, 0);
        chk("t5_done0", o_done, 0);
        chk("t5_pc0", o_fpc, 0);
        chk("t5_insn0", o_insn, 0);
        chk("t5_halted0", o_halted, 0);
        chk("t5_count0", o_count, 0);
        wait_req(10);
        chk("t5_first_addr", o_addr, RPC);

        // 6: ADD, NOP, SUB stream
        step(0, 0, 64'h0, 0);
        lat_fixed = 1;
        ovr[64'h1000] = W'(ADDW); ovr[64'h1004] = W'(NOP); ovr[64'h1008] = W'(SUBW);
        clear_logs();
        run(14, 0);
        cnt = 0; idx = -1;
        for (int i = 0; i < done_log.size(); i++) begin
            if (done_log[i] >= 64'h1000 && done_log[i] <= 64'h1008) cnt++;
            if (done_insn[i] == W'(SUBW)) idx = i;
        end
        chk("t6_pulses", cnt, NOP_PULSES);
        chk("t6_sub_found", idx >= 0, 1);
        if (idx >= 0) chk("t6_sub_pc", done_log[idx], 64'h1008);

        // Randomized run against the model
        ovr.delete(); lat_fixed = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [63:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                              : {32'h0, $urandom() & 32'hFFFF_FFFC};
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3, tgt,
                 $urandom_range(0, 499) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
